spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// Reads a run of bytes from a SPI flash through the SPI controller register port and streams them out.
// Latency: opcode + 3 address bytes (+1 dummy with SPI_FLASH_FAST_READ_EN) before the first data byte, then one byte per SPI transfer.
// Backpressure: a one-entry hold register drives out_valid; a full hold register stalls the next capture, never drops a byte.
module spi_flash_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] flash_addr,
  input  logic [15:0] byte_count,
  input  logic [1:0]  cs_sel,
  output logic        busy,
  output logic        done,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  spi_reg_addr,
  output logic [7:0]  spi_reg_wdata,
  input  logic [7:0]  spi_reg_rdata,
  output logic [1:0]  spi_reg_sel,
  output logic        spi_reg_read,
  output logic        spi_reg_write,
  input  logic        spi_int
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] READ_OPCODE = 8'h0B;
`else
  localparam logic [7:0] READ_OPCODE = 8'h03;
`endif

  // Issue states (CMD/ADDR/DUMMY/DATA/END) last exactly one cycle, so every strobe is one cycle wide.
  typedef enum logic [2:0] {
    IDLE, CMD, WAIT, ADDR, DUMMY, DATA, END, FIN
  } state_t;

  // Remembers which kind of byte the WAIT state is waiting on.
  typedef enum logic [1:0] {
    PH_CMD, PH_ADDR, PH_DUMMY, PH_DATA
  } phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        wait_first_q, wait_first_d;
  logic        done_q, done_d;

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign out_valid   = hold_full_q;
  assign out_data    = hold_q;
  assign spi_reg_sel = sel_q;

  // State and datapath registers; synchronous reset abandons any transfer silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= PH_CMD;
      idx_q        <= 2'd0;
      addr_q       <= 24'd0;
      remaining_q  <= 16'd0;
      sel_q        <= 2'd0;
      hold_q       <= 8'd0;
      hold_full_q  <= 1'b0;
      wait_first_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      sel_q        <= sel_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      wait_first_q <= wait_first_d;
      done_q       <= done_d;
    end
  end

  // Next-state, register-port strobes and hold-register handshake.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    sel_d         = sel_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    wait_first_d  = 1'b0;
    done_d        = 1'b0;
    spi_reg_write = 1'b0;
    spi_reg_read  = 1'b0;
    spi_reg_addr  = 3'd0;
    spi_reg_wdata = 8'd0;

    // Downstream consumption frees the hold register regardless of FSM state.
    if (hold_full_q && out_ready) begin
      hold_full_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = flash_addr;
          remaining_d = byte_count;
          sel_d       = cs_sel;
          idx_d       = 2'd0;
          if (byte_count == 16'd0) begin
            // Empty request completes immediately without touching the SPI port.
            done_d = 1'b1;
          end else begin
            state_d = CMD;
          end
        end
      end

      CMD: begin
        spi_reg_write = 1'b1;
        spi_reg_addr  = 3'd0;
        spi_reg_wdata = READ_OPCODE;
        phase_d       = PH_CMD;
        wait_first_d  = 1'b1;
        state_d       = WAIT;
      end

      ADDR: begin
        spi_reg_write = 1'b1;
        spi_reg_addr  = 3'd1;
        case (idx_q)
          2'd0:    spi_reg_wdata = addr_q[23:16];
          2'd1:    spi_reg_wdata = addr_q[15:8];
          default: spi_reg_wdata = addr_q[7:0];
        endcase
        phase_d      = PH_ADDR;
        wait_first_d = 1'b1;
        state_d      = WAIT;
      end

      DUMMY: begin
        spi_reg_write = 1'b1;
        spi_reg_addr  = 3'd1;
        spi_reg_wdata = 8'h00;
        phase_d       = PH_DUMMY;
        wait_first_d  = 1'b1;
        state_d       = WAIT;
      end

      DATA: begin
        spi_reg_write = 1'b1;
        spi_reg_addr  = 3'd1;
        spi_reg_wdata = 8'h00;
        phase_d       = PH_DATA;
        wait_first_d  = 1'b1;
        state_d       = WAIT;
      end

      WAIT: begin
        // Point at the data register during the data phase so rdata is the received byte.
        if (phase_q == PH_DATA) begin
          spi_reg_addr = 3'd1;
        end
        // spi_int may still show the previous byte's completion on the first cycle after a write.
        if (spi_int && !wait_first_q) begin
          case (phase_q)
            PH_CMD: begin
              idx_d   = 2'd0;
              state_d = ADDR;
            end
            PH_ADDR: begin
              if (idx_q == 2'd2) begin
`ifdef SPI_FLASH_FAST_READ_EN
                state_d = DUMMY;
`else
                state_d = DATA;
`endif
              end else begin
                idx_d   = idx_q + 2'd1;
                state_d = ADDR;
              end
            end
            PH_DUMMY: begin
              state_d = DATA;
            end
            PH_DATA: begin
              // A full hold register stalls here; spi_int stays set until the next write.
              if (!hold_full_q) begin
                hold_d      = spi_reg_rdata;
                hold_full_d = 1'b1;
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? END : DATA;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end

      END: begin
        // Register 0 read tells the controller to release chip select.
        spi_reg_read = 1'b1;
        spi_reg_addr = 3'd0;
        state_d      = FIN;
      end

      FIN: begin
        if (!hold_full_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader with a behavioural SPI controller register model.
// Expected register writes and output bytes are queued at stimulus time; monitors pop and compare.
// Stimulus is a set of directed transfers covering stall, zero length, reset abort and busy start.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] flash_addr;
  logic [15:0] byte_count;
  logic [1:0]  cs_sel;
  logic        busy;
  logic        done;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  spi_reg_addr;
  logic [7:0]  spi_reg_wdata;
  logic [7:0]  spi_reg_rdata;
  logic [1:0]  spi_reg_sel;
  logic        spi_reg_read;
  logic        spi_reg_write;
  logic        spi_int;

  always #5 clk = ~clk;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPC  = 8'h0B;
  localparam int         FD   = 5;      // index of first data write within a transfer
  localparam logic [7:0] E33  = 8'h35;  // 6th returned byte with rbase 0x30
`else
  localparam logic [7:0] OPC  = 8'h03;
  localparam int         FD   = 4;
  localparam logic [7:0] E33  = 8'h34;  // 5th returned byte with rbase 0x30
`endif

  spi_flash_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .flash_addr   (flash_addr),
    .byte_count   (byte_count),
    .cs_sel       (cs_sel),
    .busy         (busy),
    .done         (done),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .spi_reg_addr (spi_reg_addr),
    .spi_reg_wdata(spi_reg_wdata),
    .spi_reg_rdata(spi_reg_rdata),
    .spi_reg_sel  (spi_reg_sel),
    .spi_reg_read (spi_reg_read),
    .spi_reg_write(spi_reg_write),
    .spi_int      (spi_int)
  );

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  logic [10:0] exp_wr[$];
  logic [7:0]  exp_dat[$];
  logic [1:0]  exp_sel;
  logic [7:0]  rbase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPI controller model: byte completes 3 cycles after a write; returned byte = rbase + write index.
  logic [3:0] mcnt;
  logic [7:0] mnext;
  int         widx;
  always @(posedge clk) begin
    if (reset) begin
      spi_int       <= 1'b0;
      spi_reg_rdata <= 8'h00;
      mcnt          <= 4'd0;
      mnext         <= 8'h00;
      widx          <= 0;
    end else if (spi_reg_write) begin
      spi_int <= 1'b0;
      mcnt    <= 4'd3;
      mnext   <= rbase + widx[7:0];
      widx    <= widx + 1;
    end else begin
      if (spi_reg_read) widx <= 0;
      if (mcnt == 4'd1) begin
        spi_int       <= 1'b1;
        spi_reg_rdata <= mnext;
      end
      if (mcnt != 4'd0) mcnt <= mcnt - 4'd1;
    end
  end

  // Monitor: register-port strobes, done pulses and output stream.
  logic       prev_wr = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_dat = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      prev_wr    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (spi_reg_write) begin
        wr_cnt++;
        chk("wr_one_cycle", 32'(prev_wr), 32'd0);
        chk("wr_sel", 32'(spi_reg_sel), 32'(exp_sel));
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", 32'({spi_reg_addr, spi_reg_wdata}), 32'h7ff);
        end else begin
          chk("wr_addr_data", 32'({spi_reg_addr, spi_reg_wdata}), 32'(exp_wr.pop_front()));
        end
      end
      if (spi_reg_read) begin
        rd_cnt++;
        chk("rd_addr", 32'(spi_reg_addr), 32'd0);
      end
      if (done) done_cnt++;
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_stable", 32'(out_data), 32'(stall_dat));
      end
      if (out_valid && out_ready) begin
        if (exp_dat.size() == 0) begin
          chk("out_unexpected", 32'(out_data), 32'h1ff);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_dat.pop_front()));
        end
      end
      prev_wr    = spi_reg_write;
      stall_prev = out_valid && !out_ready;
      stall_dat  = out_data;
    end
  end

  task automatic push_cmd(input logic [23:0] a, input int n);
    exp_wr.push_back({3'd0, OPC});
    exp_wr.push_back({3'd1, a[23:16]});
    exp_wr.push_back({3'd1, a[15:8]});
    exp_wr.push_back({3'd1, a[7:0]});
`ifdef SPI_FLASH_FAST_READ_EN
    exp_wr.push_back({3'd1, 8'h00});
`endif
    for (int i = 0; i < n; i++) exp_wr.push_back({3'd1, 8'h00});
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] n, input logic [1:0] s);
    @(posedge clk);
    #1;
    flash_addr = a;
    byte_count = n;
    cs_sel     = s;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_write"}, 32'(spi_reg_write), 32'd0);
    chk({tag, "_read"},  32'(spi_reg_read), 32'd0);
    chk({tag, "_addr"},  32'(spi_reg_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(spi_reg_wdata), 32'd0);
    chk({tag, "_sel"},   32'(spi_reg_sel), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  int base_wr, base_rd, base_done, k;
  initial begin
    reset = 1'b1; start = 1'b0; flash_addr = 24'd0; byte_count = 16'd0;
    cs_sel = 2'd0; out_ready = 1'b1; exp_sel = 2'd0; rbase = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Basic read: 4 bytes from 0x012345, sink always ready.
    rbase = 8'hA0 - 8'(FD); exp_sel = 2'd2;
    push_cmd(24'h012345, 4);
    exp_dat.push_back(8'hA0); exp_dat.push_back(8'hA1);
    exp_dat.push_back(8'hA2); exp_dat.push_back(8'hA3);
    base_rd = rd_cnt; base_done = done_cnt;
    do_start(24'h012345, 16'd4, 2'd2);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_done("basic_done_seen", 400);
    chk("basic_reads", 32'(rd_cnt - base_rd), 32'd1);
    chk("basic_done_cnt", 32'(done_cnt - base_done), 32'd1);
    chk("basic_wr_left", 32'(exp_wr.size()), 32'd0);
    chk("basic_dat_left", 32'(exp_dat.size()), 32'd0);

    // Zero-length request: done next cycle, no busy, no SPI traffic.
    base_wr = wr_cnt; base_rd = rd_cnt; base_done = done_cnt;
    do_start(24'h777777, 16'd0, 2'd1);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("zero_busy_after", 32'(busy), 32'd0);
    end
    chk("zero_writes", 32'(wr_cnt - base_wr), 32'd0);
    chk("zero_reads", 32'(rd_cnt - base_rd), 32'd0);
    chk("zero_done_cnt", 32'(done_cnt - base_done), 32'd1);

    // Backpressure: sink stalled 200 cycles, 3 bytes.
    rbase = 8'hC1 - 8'(FD); exp_sel = 2'd1; out_ready = 1'b0;
    push_cmd(24'hABCDEF, 3);
    exp_dat.push_back(8'hC1); exp_dat.push_back(8'hC2); exp_dat.push_back(8'hC3);
    base_wr = wr_cnt;
    do_start(24'hABCDEF, 16'd3, 2'd1);
    repeat (200) @(negedge clk);
    chk("stall_writes", 32'(wr_cnt - base_wr), 32'(FD + 2));
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(out_data), 32'hC1);
    chk("stall_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("stall_done_seen", 300);
    chk("stall_writes_total", 32'(wr_cnt - base_wr), 32'(FD + 3));
    chk("stall_dat_left", 32'(exp_dat.size()), 32'd0);

    // Reset after the second address byte: abandon, then a clean transfer.
    rbase = 8'h10; exp_sel = 2'd3;
    push_cmd(24'h00FF00, 4);
    base_wr = wr_cnt; base_done = done_cnt;
    do_start(24'h00FF00, 16'd4, 2'd3);
    k = 0;
    while ((wr_cnt - base_wr) < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_addr1", 32'(wr_cnt - base_wr), 32'd3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("abort");
    exp_wr.delete();
    exp_dat.delete();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    rbase = 8'h50 - 8'(FD); exp_sel = 2'd0;
    push_cmd(24'h123456, 2);
    exp_dat.push_back(8'h50); exp_dat.push_back(8'h51);
    do_start(24'h123456, 16'd2, 2'd0);
    wait_done("abort_restart_done", 400);
    chk("abort_restart_dat_left", 32'(exp_dat.size()), 32'd0);
    chk("abort_restart_wr_left", 32'(exp_wr.size()), 32'd0);

    // Start while busy is ignored.
    rbase = 8'h70 - 8'(FD); exp_sel = 2'd1;
    push_cmd(24'h0A0B0C, 2);
    exp_dat.push_back(8'h70); exp_dat.push_back(8'h71);
    base_wr = wr_cnt; base_done = done_cnt;
    do_start(24'h0A0B0C, 16'd2, 2'd1);
    repeat (5) @(posedge clk);
    do_start(24'hFFFFFF, 16'd9, 2'd2);
    repeat (12) @(posedge clk);
    do_start(24'h111111, 16'd5, 2'd3);
    wait_done("busy_start_done", 400);
    chk("busy_start_done_cnt", 32'(done_cnt - base_done), 32'd1);
    chk("busy_start_writes", 32'(wr_cnt - base_wr), 32'(FD + 2));
    chk("busy_start_wr_left", 32'(exp_wr.size()), 32'd0);

    // Single byte from 0x000010.
    rbase = 8'h30; exp_sel = 2'd0;
    push_cmd(24'h000010, 1);
    exp_dat.push_back(E33);
    base_wr = wr_cnt;
    do_start(24'h000010, 16'd1, 2'd0);
    wait_done("single_done", 400);
    chk("single_writes", 32'(wr_cnt - base_wr), 32'(FD + 1));
    chk("single_dat_left", 32'(exp_dat.size()), 32'd0);
    chk("single_wr_left", 32'(exp_wr.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
